// File: rtl/muldiv_pkg.sv
// Shared operation encodings, FSM states and operand-sign decode for muldiv_unit.
// The op values are the funct3 codes of the M-extension, so a decoder drives op directly.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // rs1 is treated as two's complement for these ops
   function automatic logic rs1_signed(input op_e op);
      case (op)
         OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic rs2_signed(input op_e op);
      case (op)
         OP_MULH, OP_DIV, OP_REM: return 1'b1;
         default:                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle on operand magnitudes,
// sign correction and divide-by-zero handling applied in the DONE cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] op1,
   input  logic [DATA_WIDTH-1:0] op2,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
   localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
   localparam logic [2*W-1:0] ONE_2W   = {{(2*W-1){1'b0}}, 1'b1};

   state_e         r_state;
   op_e            r_op;
   logic           r_s1;
   logic           r_s2;
   logic [W-1:0]   r_acc;
   logic [W-1:0]   r_shift;
   logic [W-1:0]   r_opd;
   logic [CW-1:0]  r_cnt;
   logic           r_busy;
   logic           r_done;
   logic [W-1:0]   r_result;

   logic           w_s1;
   logic           w_s2;
   logic [W-1:0]   w_mag1;
   logic [W-1:0]   w_mag2;
   logic [W:0]     w_sum;
   logic [W:0]     w_rem_sh;
   logic           w_ge;
   logic [W-1:0]   w_diff;
   logic [W-1:0]   w_acc_nx;
   logic [W-1:0]   w_shift_nx;
   logic [2*W-1:0] w_prod;
   logic [2*W-1:0] w_prod_s;
   logic [W-1:0]   w_quo;
   logic [W-1:0]   w_rem;
   logic [W-1:0]   w_final;

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

   // Operand signs and magnitudes at capture time
   always_comb begin
      w_s1   = op1[W-1] & rs1_signed(op_e'(op));
      w_s2   = op2[W-1] & rs2_signed(op_e'(op));
      w_mag1 = w_s1 ? (~op1 + ONE_W) : op1;
      w_mag2 = w_s2 ? (~op2 + ONE_W) : op2;
   end

   // One iteration: shift-add multiply or restoring divide step
   always_comb begin
      w_sum    = {1'b0, r_acc} + {1'b0, r_opd};
      w_rem_sh = {r_acc, r_shift[W-1]};
      w_ge     = (w_rem_sh >= {1'b0, r_opd});
      w_diff   = w_rem_sh[W-1:0] - r_opd;
      if (r_op[2]) begin
         if (w_ge) begin
            w_acc_nx   = w_diff;
            w_shift_nx = {r_shift[W-2:0], 1'b1};
         end else begin
            w_acc_nx   = w_rem_sh[W-1:0];
            w_shift_nx = {r_shift[W-2:0], 1'b0};
         end
      end else if (r_shift[0]) begin
         w_acc_nx   = w_sum[W:1];
         w_shift_nx = {w_sum[0], r_shift[W-1:1]};
      end else begin
         w_acc_nx   = {1'b0, r_acc[W-1:1]};
         w_shift_nx = {r_acc[0], r_shift[W-1:1]};
      end
   end

   // Final sign correction; overflow (min / -1) falls out of the magnitude math
   always_comb begin
      w_prod   = {r_acc, r_shift};
      w_prod_s = (r_s1 ^ r_s2) ? (~w_prod + ONE_2W) : w_prod;
      w_quo    = (r_s1 ^ r_s2) ? (~r_shift + ONE_W) : r_shift;
      w_rem    = r_s1 ? (~r_acc + ONE_W) : r_acc;
      case (r_op)
         OP_MUL:                       w_final = w_prod_s[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_s[2*W-1:W];
         OP_DIV, OP_DIVU:              w_final = (r_opd == {W{1'b0}}) ? {W{1'b1}} : w_quo;
         OP_REM, OP_REMU:              w_final = w_rem;
         default:                      w_final = {W{1'b0}};
      endcase
   end

   // Control FSM with datapath registers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_op     <= OP_MUL;
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_acc    <= {W{1'b0}};
         r_shift  <= {W{1'b0}};
         r_opd    <= {W{1'b0}};
         r_cnt    <= {CW{1'b0}};
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= {W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               // a start coinciding with the done pulse is dropped
               if (start && !r_done) begin
                  r_op    <= op_e'(op);
                  r_s1    <= w_s1;
                  r_s2    <= w_s2;
                  r_acc   <= {W{1'b0}};
                  r_shift <= op[2] ? w_mag1 : w_mag2;
                  r_opd   <= op[2] ? w_mag2 : w_mag1;
                  r_cnt   <= {CW{1'b0}};
                  r_busy  <= 1'b1;
                  r_state <= ST_CALC;
               end else begin
                  r_busy  <= 1'b0;
               end
            end
            ST_CALC: begin
               r_acc   <= w_acc_nx;
               r_shift <= w_shift_nx;
               r_cnt   <= r_cnt + CNT_ONE;
               if (r_cnt == CNT_LAST) begin
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_CALC;
               end
            end
            ST_DONE: begin
               r_result <= w_final;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (DATA_WIDTH=32): directed corner cases,
// randomized operations against a 64-bit arithmetic reference, protocol and reset checks.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_checks;
   int n_pass;

   muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .op1    (op1),
      .op2    (op2),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference: RISC-V M semantics using wide native arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [63:0] p;
      int          ia;
      int          ib;
      sa = $signed(a);
      sb = $signed(b);
      ia = a;
      ib = b;
      case (o)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            return 32'(ia / ib);
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFFFFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            return 32'(ia % ib);
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(6, 0))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFFFFFF;
         3:       return 32'h80000000;
         4:       return 32'h7FFFFFFF;
         5:       return 32'($urandom_range(15, 0));
         default: return 32'($urandom());
      endcase
   endfunction

   // Issue one request, scramble inputs after capture, check latency/result/hold
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      logic [31:0] prev;
      int          cyc;
      bit          stable;
      exp = ref_model(o, a, b);
      @(negedge clk);
      start = 1'b1; op = o; op1 = a; op2 = b;
      prev = result;
      @(negedge clk);
      start = 1'b0;
      op  = 3'($urandom_range(7, 0));
      op1 = $urandom();
      op2 = $urandom();
      cyc = 1;
      stable = 1'b1;
      check({tag, " busy"}, {63'd0, busy}, 64'd1);
      while (done !== 1'b1 && cyc < 60) begin
         if (result !== prev) stable = 1'b0;
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, 64'(cyc), 64'd34);
      check({tag, " result"}, {32'd0, result}, {32'd0, exp});
      check({tag, " hold"}, {63'd0, stable}, 64'd1);
      @(negedge clk);
      check({tag, " pulse"}, {62'd0, done, busy}, 64'd0);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      int          n_done;
      int          cyc;
      bit          busy_ok;
      n_checks = 0;
      n_pass   = 0;
      rst   = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      op1   = 32'd0;
      op2   = 32'd0;
      repeat (3) @(negedge clk);
      check("reset outputs", {30'd0, busy, done, result}, 64'd0);
      rst = 1'b0;

      run_op("mul_7", 3'd0, 32'd7, 32'hFFFFFFFD);
      run_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000);
      run_op("mulhu_ones", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op("mulhsu_ones", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op("div_neg7", 3'd4, 32'hFFFFFFF9, 32'd2);
      run_op("rem_neg7", 3'd6, 32'hFFFFFFF9, 32'd2);
      run_op("divu_100", 3'd5, 32'd100, 32'd7);
      run_op("remu_100", 3'd7, 32'd100, 32'd7);
      run_op("div_by0", 3'd4, 32'd5, 32'd0);
      run_op("div_neg_by0", 3'd4, 32'hFFFFFFF0, 32'd0);
      run_op("remu_by0", 3'd7, 32'd5, 32'd0);
      run_op("rem_neg_by0", 3'd6, 32'hFFFFFFF0, 32'd0);
      run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF);
      run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF);

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(7, 0));
         ra = pick();
         rb = pick();
         run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
      end

      // start held high throughout an operation, including the done cycle
      @(negedge clk);
      start = 1'b1; op = 3'd0; op1 = 32'd7; op2 = 32'hFFFFFFFD;
      n_done  = 0;
      busy_ok = 1'b1;
      cyc     = 0;
      while (cyc < 34) begin
         @(negedge clk);
         cyc++;
         op  = 3'($urandom_range(7, 0));
         op1 = $urandom();
         op2 = $urandom();
         if (done === 1'b1) n_done++;
         if (cyc < 34 && busy !== 1'b1) busy_ok = 1'b0;
      end
      check("spam done", {63'd0, done}, 64'd1);
      check("spam result", {32'd0, result}, 64'h00000000FFFFFFEB);
      check("spam busy", {63'd0, busy_ok}, 64'd1);
      @(negedge clk);
      start = 1'b0;
      check("start at done ignored", {62'd0, busy, done}, 64'd0);
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      check("spam single done", 64'(n_done), 64'd1);

      // reset in the middle of CALC
      @(negedge clk);
      start = 1'b1; op = 3'd5; op1 = 32'd1000; op2 = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1 check("abort outputs", {30'd0, busy, done, result}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) n_done++;
      end
      check("no done after abort", 64'(n_done), 64'd0);
      run_op("after_reset", 3'd1, 32'hFFFFFFFE, 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (even, >=8).
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only when idle.
REQ-005 SHALL have port op  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port op1  input  DATA_WIDTH  multiplicand/dividend (rs1).
REQ-007 SHALL have port op2  input  DATA_WIDTH  multiplier/divisor (rs2).
REQ-008 SHALL have port busy  output  1  high while an operation is in flight.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port result  output  DATA_WIDTH  operation result.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 IDLE & start=1 SHALL capture op, op1, op2, set busy next cycle, enter CALC.
REQ-013 CALC SHALL run exactly DATA_WIDTH iterations, one bit per cycle (shift-add multiply, restoring divide on magnitudes), then enter DONE.
REQ-014 DONE SHALL assert done=1 for exactly one cycle, update result, deassert busy, return to IDLE.
REQ-015 Latency SHALL be fixed: start sampled at edge N gives done=1 in cycle after edge N+DATA_WIDTH+1, for every op and operand value.
REQ-016 start while busy=1 or done=1 SHALL be ignored; no queueing.
REQ-017 start in the same cycle done=1 is high SHALL be ignored; a new request is accepted from the following cycle in IDLE.
REQ-018 op1/op2/op changes after capture SHALL not affect the in-flight result.
REQ-019 result SHALL hold its value until the next DONE; it SHALL not glitch during CALC.
REQ-020 MUL SHALL return low DATA_WIDTH bits of product; MULH/MULHSU/MULHU SHALL return high DATA_WIDTH bits with signed*signed, signed*unsigned, unsigned*unsigned interpretation.
REQ-021 DIV/REM SHALL truncate toward zero; remainder sign SHALL equal dividend sign.
REQ-022 Divide by zero: DIV/DIVU SHALL return all-ones; REM/REMU SHALL return op1.
REQ-023 Signed overflow (op1 = most-negative, op2 = -1): DIV SHALL return op1, REM SHALL return 0.
REQ-024 Special cases of REQ-022/023 SHALL still obey REQ-015 latency.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, busy=0, done=0, result=0, all internal registers 0.
REQ-026 rst asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow release.
REQ-027 First start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-028 Op encodings and FSM state enum SHALL live in shared package muldiv_pkg.
REQ-029 No sub-module SHALL be used; datapath (accumulator, shift register, counter of $clog2(DATA_WIDTH)+1 bits) SHALL stay in muldiv_unit.
REQ-030 Operation SHALL be selectable from the existing 3-bit control style so the decoder drives op directly from funct3.

Verification (DATA_WIDTH=32)
REQ-031 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 34 cycles after start edge.
REQ-032 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14, REMU -> 2.
REQ-034 DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-035 start pulsed every cycle during an operation -> single done, busy continuous, result from first request only.
REQ-036 rst asserted at CALC iteration 10 -> busy=0, done=0, result=0 immediately; no done in next 40 cycles without new start.
